divisor_bcd_salida: RTL and testbench
=====================================

# divisor_bcd_salida

Sequential binary-to-BCD result stage placed directly downstream of the signed algorithmic divider. It detects the divider's completion, captures the two's-complement quotient and remainder, and converts their magnitudes to packed BCD with a separate sign bit for each. Conversion uses shift-and-add-3 (double dabble) on both operands in parallel. The BCD outputs drive the display/report logic.

## Interface
- `tamanyo`, default 32: width of the divider's quotient/remainder words.
- `DIGITOS`, default 10: BCD digits per result. Must satisfy 10^DIGITOS > 2^(tamanyo-1).
- `CLK` input, 1 bit: single clock, rising edge.
- `RST` input, 1 bit: reset, synchronous and active-high.
- `Done_in` input, 1 bit: divider Done. A level signal that stays high while the divider holds its result.
- `Coc_in` input, tamanyo bits: divider quotient, two's complement.
- `Res_in` input, tamanyo bits: divider remainder, two's complement.
- `BCD_Coc` output, 4*DIGITOS bits: quotient magnitude as packed BCD, least-significant digit in [3:0].
- `BCD_Res` output, 4*DIGITOS bits: remainder magnitude as packed BCD.
- `Sign_Coc`, `Sign_Res` outputs, 1 bit each: 1 = negative.
- `Valid` output, 1 bit: outputs hold a completed conversion.
- `Busy` output, 1 bit: conversion in progress.

## Operation
- Start detection:
  - `Done_prev` registers `Done_in` every cycle.
  - A start is `Done_in & ~Done_prev` sampled while in S_IDLE.
  - Starts seen in any other state are ignored. `Done_prev` still tracks in every state.
- S_IDLE, on start:
  - `Sign_x <= x_in[tamanyo-1]`.
  - Magnitude register `<= MSB ? (~x_in+1) : x_in`, tamanyo bits unsigned. 0x80..0 gives magnitude 2^(tamanyo-1).
  - Clear BCD shift registers.
  - `CONT <= tamanyo-1`.
  - `Valid <= 0`.
  - Go to S_AJUSTE.
- S_AJUSTE: every BCD nibble ≥ 5 gets +3, in both shift registers at once. Go to S_DESPLAZA.
- S_DESPLAZA:
  - `{bcd, mag} <= {bcd, mag} << 1` for each operand.
  - `CONT <= CONT-1`.
  - If `CONT == 0`, go to S_FIN; else go to S_AJUSTE.
- S_FIN:
  - Copy the BCD shift registers to `BCD_Coc`/`BCD_Res`.
  - `Valid <= 1`.
  - Go to S_IDLE.
- Outputs hold until the next start. A start clears `Valid` in the same edge that leaves S_IDLE.
- `Busy` is 1 in S_AJUSTE, S_DESPLAZA and S_FIN. It is 0 in S_IDLE.
- Sign bits come straight from the input MSB; a zero value has sign 0 automatically. The upper BCD digits beyond the value are 0.

## Timing
- Reset values:
  - State is S_IDLE.
  - `BCD_Coc`, `BCD_Res`, `Sign_Coc`, `Sign_Res`, `Valid`, `Busy` and `Done_prev` are all 0.
- Latency: the start is sampled at edge N. `Valid` is high after edge N + 2·tamanyo + 1, which is 65 cycles for tamanyo = 32.
- Back-to-back: the earliest next start is sampled at edge N + 2·tamanyo + 2. `Done_in` must have been low for at least one sampled cycle before it.
- `Coc_in`/`Res_in` are sampled only at the start edge. Later input changes have no effect on the current conversion.
- Reset mid-conversion:
  - All state returns to reset values and the partial result is discarded.
  - `Done_prev` resets to 0, so a `Done_in` still high on the first cycle after reset triggers exactly one new conversion.
- Reset has priority over every transition.

## Structure
- Package `divisor_pkg`:
  - `typedef enum logic [1:0] {S_IDLE, S_AJUSTE, S_DESPLAZA, S_FIN} estado_bcd_t`.
  - Default constants `TAMANYO_DEF = 32` and `DIGITOS_DEF = 10`.
- Sub-module `ajuste_bcd #(DIGITOS)`:
  - Combinational per-nibble "≥5 → +3" corrector over a 4*DIGITOS vector.
  - Instantiated twice, once for the quotient and once for the remainder.
- Top holds the FSM, counter, edge detector and registers. Target RTL is about 150–200 lines.

## Test plan
- Quotient 3, remainder 1 (7/2):
  - Stimulus: Coc_in = 32'd3, Res_in = 32'd1, rising `Done_in`.
  - Response after 65 cycles: `BCD_Coc` = 40'h0000000003, `BCD_Res` = 40'h0000000001, both signs 0, `Valid` = 1.
- Negative quotient:
  - Stimulus: Coc_in = 32'hFFFFFFFD, Res_in = 32'hFFFFFFFF.
  - Response: `BCD_Coc` = 40'h0000000003 with `Sign_Coc` = 1; `BCD_Res` = 40'h0000000001 with `Sign_Res` = 1.
- Extreme values:
  - Stimulus: Coc_in = 32'h80000000, Res_in = 32'h7FFFFFFF.
  - Response: `BCD_Coc` = 40'h2147483648 with `Sign_Coc` = 1; `BCD_Res` = 40'h2147483647 with `Sign_Res` = 0.
- `Done_in` held high for 200 cycles:
  - Response: exactly one conversion runs; `Busy` is high for 65 cycles total.
  - Changing Coc_in at cycle 10 leaves the result unchanged.
- Reset mid-conversion:
  - Stimulus: `RST` = 1 at cycle 20 of a conversion, with `Done_in` low.
  - Response: all outputs are 0 next cycle and the block stays idle.
  - Repeat with `Done_in` held high: one fresh conversion completes 65 cycles after reset is released.
- Back-to-back:
  - Stimulus: a second `Done_in` pulse (low then high) while `Busy` = 1, then another after `Valid` rises.
  - Response: the first pulse is ignored. The second clears `Valid` at its start edge and delivers new values 65 cycles later.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared types and defaults for the divider BCD result stage.
package divisor_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AJUSTE,
    S_DESPLAZA,
    S_FIN
  } estado_bcd_t;

  localparam int TAMANYO_DEF = 32;
  localparam int DIGITOS_DEF = 10;

  function automatic int ancho_cont(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/ajuste_bcd.sv
// Per-nibble double-dabble corrector: digits >= 5 get +3.
module ajuste_bcd #(
  parameter int DIGITOS = 10
) (
  input  logic [4*DIGITOS-1:0] i_bcd,
  output logic [4*DIGITOS-1:0] o_bcd
);

  for (genvar g = 0; g < DIGITOS; g++) begin : g_dig
    logic [3:0] w_nib;
    assign w_nib = i_bcd[4*g +: 4];
    assign o_bcd[4*g +: 4] =
      (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
  end

endmodule

// File: rtl/divisor_bcd_salida.sv
// Divider result stage: captures signed quotient/remainder on Done
// and converts both magnitudes to packed BCD by shift-and-add-3.
module divisor_bcd_salida
  import divisor_pkg::*;
#(
  parameter int tamanyo = TAMANYO_DEF,
  parameter int DIGITOS = DIGITOS_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Done_in,
  input  logic [tamanyo-1:0]   Coc_in,
  input  logic [tamanyo-1:0]   Res_in,
  output logic [4*DIGITOS-1:0] BCD_Coc,
  output logic [4*DIGITOS-1:0] BCD_Res,
  output logic                 Sign_Coc,
  output logic                 Sign_Res,
  output logic                 Valid,
  output logic                 Busy
);

  localparam int W  = 4 * DIGITOS;
  localparam int CW = ancho_cont(tamanyo);
  localparam logic [CW-1:0] CONT_INI = CW'(tamanyo - 1);
  localparam logic [CW-1:0] CONT_UNO = CW'(1);
  localparam logic [tamanyo-1:0] UNO = tamanyo'(1);

  estado_bcd_t r_estado;
  estado_bcd_t w_sig;

  logic               r_done_prev;
  logic               w_start;
  logic [CW-1:0]      r_cont;
  logic [tamanyo-1:0] r_mag_coc;
  logic [tamanyo-1:0] r_mag_res;
  logic [W-1:0]       r_sh_coc;
  logic [W-1:0]       r_sh_res;
  logic [W-1:0]       w_adj_coc;
  logic [W-1:0]       w_adj_res;
  logic [W-1:0]       r_bcd_coc;
  logic [W-1:0]       r_bcd_res;
  logic               r_sign_coc;
  logic               r_sign_res;
  logic               r_valid;

  assign w_start = Done_in & ~r_done_prev;

  ajuste_bcd #(.DIGITOS(DIGITOS)) u_adj_coc (
    .i_bcd (r_sh_coc),
    .o_bcd (w_adj_coc)
  );

  ajuste_bcd #(.DIGITOS(DIGITOS)) u_adj_res (
    .i_bcd (r_sh_res),
    .o_bcd (w_adj_res)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_estado <= S_IDLE;
    else     r_estado <= w_sig;
  end

  always_comb begin
    w_sig = r_estado;
    unique case (r_estado)
      S_IDLE:     if (w_start) w_sig = S_AJUSTE;
      S_AJUSTE:   w_sig = S_DESPLAZA;
      S_DESPLAZA: w_sig = (r_cont == '0) ? S_FIN : S_AJUSTE;
      S_FIN:      w_sig = S_IDLE;
      default:    w_sig = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_done_prev <= 1'b0;
      r_cont      <= '0;
      r_mag_coc   <= '0;
      r_mag_res   <= '0;
      r_sh_coc    <= '0;
      r_sh_res    <= '0;
      r_bcd_coc   <= '0;
      r_bcd_res   <= '0;
      r_sign_coc  <= 1'b0;
      r_sign_res  <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_done_prev <= Done_in;
      unique case (r_estado)
        S_IDLE: begin
          if (w_start) begin
            r_sign_coc <= Coc_in[tamanyo-1];
            r_sign_res <= Res_in[tamanyo-1];
            r_mag_coc  <= Coc_in[tamanyo-1] ?
                          (~Coc_in + UNO) : Coc_in;
            r_mag_res  <= Res_in[tamanyo-1] ?
                          (~Res_in + UNO) : Res_in;
            r_sh_coc   <= '0;
            r_sh_res   <= '0;
            r_cont     <= CONT_INI;
            r_valid    <= 1'b0;
          end
        end
        S_AJUSTE: begin
          r_sh_coc <= w_adj_coc;
          r_sh_res <= w_adj_res;
        end
        S_DESPLAZA: begin
          // Magnitude MSB feeds the BCD LSB on each shift.
          r_sh_coc  <= {r_sh_coc[W-2:0], r_mag_coc[tamanyo-1]};
          r_sh_res  <= {r_sh_res[W-2:0], r_mag_res[tamanyo-1]};
          r_mag_coc <= {r_mag_coc[tamanyo-2:0], 1'b0};
          r_mag_res <= {r_mag_res[tamanyo-2:0], 1'b0};
          r_cont    <= r_cont - CONT_UNO;
        end
        S_FIN: begin
          r_bcd_coc <= r_sh_coc;
          r_bcd_res <= r_sh_res;
          r_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BCD_Coc  = r_bcd_coc;
  assign BCD_Res  = r_bcd_res;
  assign Sign_Coc = r_sign_coc;
  assign Sign_Res = r_sign_res;
  assign Valid    = r_valid;
  assign Busy     = (r_estado != S_IDLE);

endmodule

// File: tb/tb_divisor_bcd_salida.sv
// Self-checking bench for divisor_bcd_salida (32-bit, 10 digits).
module tb_divisor_bcd_salida;

  localparam int T = 32;
  localparam int D = 10;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Done_in;
  logic [T-1:0]  Coc_in;
  logic [T-1:0]  Res_in;
  logic [4*D-1:0] BCD_Coc;
  logic [4*D-1:0] BCD_Res;
  logic          Sign_Coc;
  logic          Sign_Res;
  logic          Valid;
  logic          Busy;

  divisor_bcd_salida #(.tamanyo(T), .DIGITOS(D)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Done_in  (Done_in),
    .Coc_in   (Coc_in),
    .Res_in   (Res_in),
    .BCD_Coc  (BCD_Coc),
    .BCD_Res  (BCD_Res),
    .Sign_Coc (Sign_Coc),
    .Sign_Res (Sign_Res),
    .Valid    (Valid),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [T-1:0]   coc;
    logic [T-1:0]   res;
    logic [4*D-1:0] bc;
    logic [4*D-1:0] br;
    logic           sc;
    logic           sr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [4*D-1:0] to_bcd(input logic [T-1:0] v);
    longint m;
    logic [4*D-1:0] r;
    r = '0;
    m = v[T-1] ? (64'h1_0000_0000 - longint'(v)) : longint'(v);
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [T-1:0] c,
                              input logic [T-1:0] r);
    vec_t v;
    v.coc = c;
    v.res = r;
    v.bc  = to_bcd(c);
    v.br  = to_bcd(r);
    v.sc  = c[T-1];
    v.sr  = r[T-1];
    return v;
  endfunction

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic compare(input string n);
    vec_t e;
    if (sb.size() == 0) begin
      chk({n, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({n, "_bcd_coc"}, 64'(BCD_Coc), 64'(e.bc));
    chk({n, "_bcd_res"}, 64'(BCD_Res), 64'(e.br));
    chk({n, "_sign_coc"}, 64'(Sign_Coc), 64'(e.sc));
    chk({n, "_sign_res"}, 64'(Sign_Res), 64'(e.sr));
  endtask

  task automatic wait_valid(output int busy, output int lat,
                            output bit ok);
    busy = 0;
    lat  = 0;
    ok   = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge CLK);
      if (Busy) busy++;
      if (Valid) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic run(input vec_t v, input string n);
    int busy, lat;
    bit ok;
    @(negedge CLK);
    Done_in = 1'b0;
    @(negedge CLK);
    Coc_in  = v.coc;
    Res_in  = v.res;
    Done_in = 1'b1;
    sb.push_back(v);
    wait_valid(busy, lat, ok);
    chk({n, "_timeout"}, 64'(ok), 64'd1);
    chk({n, "_lat"}, 64'(lat), 64'd66);
    chk({n, "_busy"}, 64'(busy), 64'd65);
    compare(n);
    Done_in = 1'b0;
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_bcd_coc"}, 64'(BCD_Coc), 64'd0);
    chk({n, "_bcd_res"}, 64'(BCD_Res), 64'd0);
    chk({n, "_sign_coc"}, 64'(Sign_Coc), 64'd0);
    chk({n, "_sign_res"}, 64'(Sign_Res), 64'd0);
    chk({n, "_valid"}, 64'(Valid), 64'd0);
    chk({n, "_busy"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    int busy, lat, rises, act;
    bit ok, pv;
    vec_t v;

    RST     = 1'b1;
    Done_in = 1'b0;
    Coc_in  = '0;
    Res_in  = '0;

    tbl.push_back('{32'd3, 32'd1, 40'h3, 40'h1, 1'b0, 1'b0});
    tbl.push_back('{32'hFFFFFFFD, 32'hFFFFFFFF,
                    40'h3, 40'h1, 1'b1, 1'b1});
    tbl.push_back('{32'h80000000, 32'h7FFFFFFF,
                    40'h2147483648, 40'h2147483647, 1'b1, 1'b0});
    tbl.push_back('{32'd0, 32'd999, 40'h0, 40'h999, 1'b0, 1'b0});
    tbl.push_back('{32'd59595, 32'hFFFFFFF6,
                    40'h59595, 40'h10, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk($urandom, $urandom));

    repeat (2) @(negedge CLK);
    chk_zero("reset");
    RST = 1'b0;

    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // Done held high: one conversion, input change ignored
    v = mk(32'd4096, 32'hFFFFFF85);
    @(negedge CLK);
    Coc_in  = v.coc;
    Res_in  = v.res;
    Done_in = 1'b1;
    sb.push_back(v);
    busy  = 0;
    rises = 0;
    pv    = Valid;
    for (int i = 1; i <= 200; i++) begin
      @(negedge CLK);
      if (Busy) busy++;
      if (Valid && !pv) rises++;
      pv = Valid;
      if (i == 10) Coc_in = 32'h12345678;
    end
    chk("hold_busy", 64'(busy), 64'd65);
    chk("hold_rises", 64'(rises), 64'd1);
    compare("hold");
    Done_in = 1'b0;

    // Reset mid-conversion, Done low
    v = mk(32'd777, 32'd5);
    @(negedge CLK);
    Coc_in  = v.coc;
    Res_in  = v.res;
    Done_in = 1'b1;
    @(negedge CLK);
    Done_in = 1'b0;
    repeat (19) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk_zero("rst_mid");
    RST = 1'b0;
    act = 0;
    repeat (80) begin
      @(negedge CLK);
      if (Busy || Valid) act++;
    end
    chk("rst_idle", 64'(act), 64'd0);

    // Reset mid-conversion, Done held high
    v = mk(32'hFFFF0000, 32'd31415);
    Coc_in  = v.coc;
    Res_in  = v.res;
    Done_in = 1'b1;
    repeat (20) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk_zero("rst_hi");
    sb.push_back(v);
    RST = 1'b0;
    wait_valid(busy, lat, ok);
    chk("rst_hi_timeout", 64'(ok), 64'd1);
    chk("rst_hi_lat", 64'(lat), 64'd66);
    chk("rst_hi_busy", 64'(busy), 64'd65);
    compare("rst_hi");
    Done_in = 1'b0;

    // Back-to-back: pulse during Busy ignored, next after Valid
    v = mk(32'd123456789, 32'hFFFFFF00);
    @(negedge CLK);
    @(negedge CLK);
    Coc_in  = v.coc;
    Res_in  = v.res;
    Done_in = 1'b1;
    sb.push_back(v);
    repeat (10) @(negedge CLK);
    Done_in = 1'b0;
    @(negedge CLK);
    Coc_in  = 32'd42;
    Done_in = 1'b1;
    wait_valid(busy, lat, ok);
    chk("b2b_a_timeout", 64'(ok), 64'd1);
    compare("b2b_a");
    v = mk(32'd42, 32'd8);
    @(negedge CLK);
    Done_in = 1'b0;
    @(negedge CLK);
    Coc_in  = v.coc;
    Res_in  = v.res;
    Done_in = 1'b1;
    sb.push_back(v);
    @(negedge CLK);
    chk("b2b_valid_clr", 64'(Valid), 64'd0);
    chk("b2b_busy", 64'(Busy), 64'd1);
    wait_valid(busy, lat, ok);
    chk("b2b_b_timeout", 64'(ok), 64'd1);
    chk("b2b_b_lat", 64'(lat), 64'd65);
    compare("b2b_b");
    Done_in = 1'b0;

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
